// File: rtl/otg_hpi_bus_sequencer.sv
// otg_hpi_bus_sequencer: Avalon-MM slave that runs one CY7C67200 HPI access per request (cs/rd/wr strobes timed in hardware)
// Latency: 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOVERY_CYC clk per access (7 with defaults); posted writes complete in 1 clk
// Backpressure: waitrequest = req & ~done; done is the last RECOVER cycle; a req arriving while busy waits until the FSM is back in IDLE
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   address/chipselect/read/write/writedata/readdata/waitrequest   Avalon-MM slave (register index = HPI A[1:0])
//   hpi_addr, hpi_data_out, hpi_data_oe, hpi_data_in, hpi_cs_n, hpi_rd_n, hpi_wr_n   HPI pins (all outputs registered)
//   busy                         1 whenever the sequencer is not IDLE
// Optional feature: define HPI_POSTED_WRITE_EN to acknowledge writes in their accept cycle and run them in the background.

module otg_hpi_bus_sequencer #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 2,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        busy
);

`ifdef HPI_POSTED_WRITE_EN
    localparam logic POSTED_WR = 1'b1;
`else
    localparam logic POSTED_WR = 1'b0;
`endif

    // Phase lengths; a zero-length phase would never reach the count of 1, so it is stretched to one cycle.
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LD   = (SETUP_CYC    == 0) ? ONE : CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD  = (STROBE_CYC   == 0) ? ONE : CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD    = (HOLD_CYC     == 0) ? ONE : CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] RECOVER_LD = (RECOVERY_CYC == 0) ? ONE : CNT_W'(RECOVERY_CYC);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_rd_q, is_rd_d;
    logic              posted_q, posted_d;
    logic [1:0]        hpi_addr_q, hpi_addr_d;
    logic [15:0]       hpi_data_out_q, hpi_data_out_d;
    logic [15:0]       readdata_q, readdata_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;

    logic req;
    logic last_cyc;
    logic done;
    logic accept;
    logic cs_active;

    assign req      = chipselect & (read | write);
    assign last_cyc = (cnt_q == ONE);
    assign done     = (state_q == ST_RECOVER) & last_cyc;
    assign accept   = (state_q == ST_IDLE) & req;

    // A posted write is released in its accept cycle; its own completion must then not
    // release whichever request happens to be waiting during its last RECOVER cycle.
    assign waitrequest = req & ~((done & ~posted_q) | (accept & POSTED_WR & ~read));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        is_rd_d        = is_rd_q;
        posted_d       = posted_q;
        hpi_addr_d     = hpi_addr_q;
        hpi_data_out_d = hpi_data_out_q;
        readdata_d     = readdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // read wins when read and write are both asserted
                    state_d    = ST_SETUP;
                    cnt_d      = SETUP_LD;
                    is_rd_d    = read;
                    posted_d   = POSTED_WR & ~read;
                    hpi_addr_d = address;
                    if (!read) begin
                        hpi_data_out_d = writedata;
                    end
                end
            end
            ST_SETUP: begin
                if (last_cyc) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_STROBE: begin
                if (last_cyc) begin
                    // the chip's data is only guaranteed settled at the end of the strobe
                    if (is_rd_q) begin
                        readdata_d = hpi_data_in;
                    end
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_HOLD: begin
                if (last_cyc) begin
                    state_d = ST_RECOVER;
                    cnt_d   = RECOVER_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_RECOVER: begin
                if (last_cyc) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    posted_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pin values are decoded from the next state so the flops present them in the same
        // cycle the FSM occupies that state.
        cs_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_n_d    = ~cs_active;
        rd_n_d    = ~((state_d == ST_STROBE) & is_rd_d);
        wr_n_d    = ~((state_d == ST_STROBE) & ~is_rd_d);
        oe_d      = cs_active & ~is_rd_d;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            is_rd_q        <= 1'b0;
            posted_q       <= 1'b0;
            hpi_addr_q     <= 2'd0;
            hpi_data_out_q <= 16'd0;
            readdata_q     <= 16'd0;
            cs_n_q         <= 1'b1;
            rd_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            oe_q           <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            is_rd_q        <= is_rd_d;
            posted_q       <= posted_d;
            hpi_addr_q     <= hpi_addr_d;
            hpi_data_out_q <= hpi_data_out_d;
            readdata_q     <= readdata_d;
            cs_n_q         <= cs_n_d;
            rd_n_q         <= rd_n_d;
            wr_n_q         <= wr_n_d;
            oe_q           <= oe_d;
            busy_q         <= busy_d;
        end
    end

    assign readdata     = readdata_q;
    assign hpi_addr     = hpi_addr_q;
    assign hpi_data_out = hpi_data_out_q;
    assign hpi_data_oe  = oe_q;
    assign hpi_cs_n     = cs_n_q;
    assign hpi_rd_n     = rd_n_q;
    assign hpi_wr_n     = wr_n_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_otg_hpi_bus_sequencer.sv
// tb_otg_hpi_bus_sequencer: directed + random Avalon accesses, expected HPI cycles and Avalon completions queued at issue
// Latency: reference model tracks when the sequencer is next free and derives each access's accept cycle from that
// Backpressure: driver holds each request until waitrequest is low; monitors pop and compare independently

module tb_otg_hpi_bus_sequencer;

`ifdef HPI_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam int SETUP_N  = 1;
    localparam int STROBE_N = 2;
    localparam int HOLD_N   = 1;
    localparam int RECOV_N  = 2;
    localparam int CS_LEN   = SETUP_N + STROBE_N + HOLD_N;
    localparam int OCC      = 1 + SETUP_N + STROBE_N + HOLD_N + RECOV_N;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic        busy;

    otg_hpi_bus_sequencer #(
        .SETUP_CYC    (SETUP_N),
        .STROBE_CYC   (STROBE_N),
        .HOLD_CYC     (HOLD_N),
        .RECOVERY_CYC (RECOV_N),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .hpi_addr     (hpi_addr),
        .hpi_data_out (hpi_data_out),
        .hpi_data_oe  (hpi_data_oe),
        .hpi_data_in  (hpi_data_in),
        .hpi_cs_n     (hpi_cs_n),
        .hpi_rd_n     (hpi_rd_n),
        .hpi_wr_n     (hpi_wr_n),
        .busy         (busy)
    );

    typedef struct {
        int  addr;
        bit  is_wr;
        int  wdata;
        int  start;
    } hpi_exp_t;

    typedef struct {
        bit  is_rd;
        int  rdata;
        int  lat;
    } av_exp_t;

    hpi_exp_t    hpi_exp_q[$];
    av_exp_t     av_exp_q[$];
    logic [15:0] chip_rv_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int free_cyc = 0;
    bit mon_en   = 0;
    bit chip_vary = 0;
    int bus_viol = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one access (caller is just after a rising edge), queue its expected effects, and hold it until accepted.
    task automatic do_access(input logic [1:0] a, input bit rd, input bit wr,
                             input logic [15:0] wd, input logic [15:0] rv);
        hpi_exp_t he;
        av_exp_t  ae;
        int  c;
        int  acc;
        bit  is_rd;
        bit  posted;
        bit  ok;
        c      = cyc;
        acc    = (c > free_cyc) ? c : free_cyc;
        is_rd  = rd;
        posted = POSTED && !is_rd;
        he.addr  = int'(a);
        he.is_wr = !is_rd;
        he.wdata = int'(wd);
        he.start = acc + 1;
        ae.is_rd = is_rd;
        ae.rdata = int'(rv);
        ae.lat   = posted ? (acc - c + 1) : (acc + OCC - c);
        free_cyc = acc + OCC;
        hpi_exp_q.push_back(he);
        av_exp_q.push_back(ae);
        if (is_rd) chip_rv_q.push_back(rv);

        address    = a;
        chipselect = 1'b1;
        read       = rd;
        write      = wr;
        writedata  = wd;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("access_completes", 0, 1);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (hpi_exp_q.size() == 0 && av_exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    // Chip model: returns the queued value while rd_n is low. With chip_vary set, strobe
    // cycles before the last one carry the complement, so only a last-cycle sample is right.
    logic [15:0] cur_rv = 16'hBEEF;
    logic        prev_rd_n = 1'b1;
    int          rd_low = 0;
    always @(negedge clk) begin
        if (!hpi_rd_n && prev_rd_n) begin
            if (chip_rv_q.size() != 0) cur_rv = chip_rv_q.pop_front();
            else                       cur_rv = 16'hBEEF;
            rd_low = 0;
        end
        prev_rd_n = hpi_rd_n;
        if (!hpi_rd_n) begin
            rd_low++;
            hpi_data_in = (chip_vary && rd_low < STROBE_N) ? ~cur_rv : cur_rv;
        end else begin
            hpi_data_in = 16'h0000;
        end
    end

    // HPI monitor: collect each cs_n-low window and compare it with the next expected cycle.
    bit          in_win = 0;
    int          w_start, w_len, s_start, s_len, oe_cnt;
    bit          rd_seen, wr_seen, unstable;
    logic [1:0]  w_addr;
    logic [15:0] w_data;
    always @(negedge clk) begin
        if (!mon_en || !reset_n) begin
            in_win = 1'b0;
        end else if (!hpi_cs_n) begin
            if (!in_win) begin
                in_win   = 1'b1;
                w_start  = cyc;
                w_len    = 0;
                s_start  = -1;
                s_len    = 0;
                oe_cnt   = 0;
                rd_seen  = 1'b0;
                wr_seen  = 1'b0;
                unstable = 1'b0;
                w_addr   = hpi_addr;
                w_data   = hpi_data_out;
            end
            if (hpi_addr != w_addr || (hpi_data_oe && hpi_data_out != w_data)) unstable = 1'b1;
            if (!busy) bus_viol++;
            if (!hpi_rd_n || !hpi_wr_n) begin
                if (s_start < 0) s_start = w_len;
                s_len++;
            end
            rd_seen = rd_seen | !hpi_rd_n;
            wr_seen = wr_seen | !hpi_wr_n;
            if (hpi_data_oe) oe_cnt++;
            w_len++;
        end else begin
            if (!hpi_rd_n || !hpi_wr_n || hpi_data_oe) bus_viol++;
            if (in_win) begin
                in_win = 1'b0;
                if (hpi_exp_q.size() == 0) begin
                    chk("hpi_unexpected_cycle", 1, 0);
                end else begin
                    hpi_exp_t e;
                    e = hpi_exp_q.pop_front();
                    chk("hpi_cs_start_cycle", w_start, e.start);
                    chk("hpi_cs_len", w_len, CS_LEN);
                    chk("hpi_strobe_offset", s_start, SETUP_N);
                    chk("hpi_strobe_len", s_len, STROBE_N);
                    chk("hpi_addr", int'(w_addr), e.addr);
                    chk("hpi_kind_rd_wr", int'({rd_seen, wr_seen}), e.is_wr ? 1 : 2);
                    chk("hpi_addr_data_stable", int'(unstable), 0);
                    chk("hpi_oe_cycles", oe_cnt, e.is_wr ? CS_LEN : 0);
                    if (e.is_wr) chk("hpi_write_data", int'(w_data), e.wdata);
                end
            end
        end
    end

    // Avalon monitor: count request cycles; on completion compare occupancy and read data.
    int lat_cnt = 0;
    always @(negedge clk) begin
        if (!mon_en || !reset_n) begin
            lat_cnt = 0;
        end else if (chipselect && (read || write)) begin
            lat_cnt++;
            if (!waitrequest) begin
                if (av_exp_q.size() == 0) begin
                    chk("av_unexpected_completion", 1, 0);
                end else begin
                    av_exp_t e;
                    e = av_exp_q.pop_front();
                    chk("av_occupancy", lat_cnt, e.lat);
                    if (e.is_rd) chk("av_readdata", int'(readdata), e.rdata);
                end
                lat_cnt = 0;
            end
        end
    end

    initial begin
        bit got;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = 16'd0;
        idle(2);

        chk("rst_cs_n", int'(hpi_cs_n), 1);
        chk("rst_rd_n", int'(hpi_rd_n), 1);
        chk("rst_wr_n", int'(hpi_wr_n), 1);
        chk("rst_oe", int'(hpi_data_oe), 0);
        chk("rst_hpi_addr", int'(hpi_addr), 0);
        chk("rst_hpi_data_out", int'(hpi_data_out), 0);
        chk("rst_readdata", int'(readdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_waitrequest_idle", int'(waitrequest), 0);
        chipselect = 1'b1;
        read       = 1'b1;
        #1;
        chk("rst_waitrequest_req", int'(waitrequest), 1);
        chipselect = 1'b0;
        read       = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        free_cyc = cyc;
        mon_en   = 1'b1;

        // directed cases
        do_access(2'd2, 1'b0, 1'b1, 16'h1234, 16'h0000);
        idle(2);
        do_access(2'd0, 1'b1, 1'b0, 16'h0000, 16'hBEEF);
        idle(1);
        do_access(2'd1, 1'b0, 1'b1, 16'hA5C3, 16'h0000);
        do_access(2'd3, 1'b1, 1'b0, 16'h0000, 16'h7E01);
        idle(1);
        do_access(2'd0, 1'b1, 1'b1, 16'hFFFF, 16'h5A5A);
        idle(1);
        do_access(2'd2, 1'b0, 1'b1, 16'hCAFE, 16'h0000);
        do_access(2'd1, 1'b1, 1'b0, 16'h0000, 16'h0F0F);
        drain();
        idle(2);

        // asynchronous reset in the middle of a read strobe
        mon_en     = 1'b0;
        address    = 2'd0;
        chipselect = 1'b1;
        read       = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!hpi_rd_n) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_mid_strobe_reached", int'(got), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cs_n", int'(hpi_cs_n), 1);
        chk("rst_mid_rd_n", int'(hpi_rd_n), 1);
        chk("rst_mid_wr_n", int'(hpi_wr_n), 1);
        chk("rst_mid_oe", int'(hpi_data_oe), 0);
        chk("rst_mid_readdata", int'(readdata), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_waitrequest", int'(waitrequest), 1);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chip_rv_q.delete();
        free_cyc = cyc;
        mon_en   = 1'b1;
        do_access(2'd2, 1'b1, 1'b0, 16'h0000, 16'h3C3C);
        idle(1);

        // random traffic
        chip_vary = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int k;
            int gap;
            k   = $urandom_range(0, 4);
            gap = $urandom_range(0, 2);
            do_access(2'($urandom_range(0, 3)), (k <= 1) || (k == 4), (k >= 2),
                      16'($urandom), 16'($urandom));
            if (gap > 0) idle(gap);
        end
        drain();
        idle(OCC);

        chk("end_hpi_queue_empty", hpi_exp_q.size(), 0);
        chk("end_av_queue_empty", av_exp_q.size(), 0);
        chk("end_chip_queue_empty", chip_rv_q.size(), 0);
        chk("bus_quiet_outside_cs_and_busy_inside", bus_viol, 0);
        chk("end_busy", int'(busy), 0);
        chk("end_cs_n", int'(hpi_cs_n), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
